// File: rtl/rr_arb_mux.sv
// N-to-1 word multiplexer with per-channel valid/ready, fixed-priority or
// round-robin arbitration, a force-select mode and one registered output stage.
module rr_arb_mux #(
  parameter int WIDTH    = 32,
  parameter int N_IN     = 4,
  parameter int ARB_MODE = 1,
  localparam int SEL_W   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  input  logic                    force_en,
  input  logic [SEL_W-1:0]        force_sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic [SEL_W-1:0] outSel_q, outSel_d;
  logic             outValid_q, outValid_d;

  logic [N_IN-1:0]  elig;
  logic             anyElig;
  logic             load;
  logic [SEL_W-1:0] grant;
  logic             grantFound;
  logic [WIDTH-1:0] selData;

  // An out-of-range force_sel matches no channel, leaving the eligible set empty.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_IN; i++) begin
      elig[i] = in_valid[i] & (!force_en | (force_sel == SEL_W'(i)));
    end
  end

  assign anyElig = |elig;
  assign load    = !outValid_q | out_ready;

  // Round-robin scans ptr..N_IN-1 first, then wraps to the lowest eligible index.
  always_comb begin
    grant      = '0;
    grantFound = 1'b0;
    if (ARB_MODE == 1 && !force_en) begin
      for (int i = 0; i < N_IN; i++) begin
        if (!grantFound && elig[i] && (SEL_W'(i) >= ptr_q)) begin
          grant      = SEL_W'(i);
          grantFound = 1'b1;
        end
      end
    end
    for (int i = 0; i < N_IN; i++) begin
      if (!grantFound && elig[i]) begin
        grant      = SEL_W'(i);
        grantFound = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    selData  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = rst_n & load & anyElig;
        selData     = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    outData_d  = outData_q;
    outSel_d   = outSel_q;
    outValid_d = outValid_q;
    if (load) begin
      if (anyElig) begin
        outData_d  = selData;
        outSel_d   = grant;
        outValid_d = 1'b1;
        if (ARB_MODE == 1 && !force_en) begin
          ptr_d = (grant == SEL_W'(N_IN - 1)) ? '0 : grant + 1'b1;
        end
      end else begin
        outValid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      outData_q  <= '0;
      outSel_q   <= '0;
      outValid_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      outData_q  <= outData_d;
      outSel_q   <= outSel_d;
      outValid_q <= outValid_d;
    end
  end

  assign out_data  = outData_q;
  assign out_sel   = outSel_q;
  assign out_valid = outValid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: round-robin, fixed-priority, force-select,
// out-of-range force, 2:1 legacy use and asynchronous reset.
module tb_rr_arb_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checkCount = 0;
  int failCount  = 0;

  // Round-robin instance, N_IN=4
  logic [127:0] rrInData;
  logic [3:0]   rrInValid, rrInReady;
  logic         rrForceEn, rrOutValid, rrOutReady;
  logic [1:0]   rrForceSel, rrOutSel;
  logic [31:0]  rrOutData;

  // Fixed-priority instance, N_IN=4
  logic [127:0] fpInData;
  logic [3:0]   fpInValid, fpInReady;
  logic         fpForceEn, fpOutValid, fpOutReady;
  logic [1:0]   fpForceSel, fpOutSel;
  logic [31:0]  fpOutData;

  // Three-channel instance, lets force_sel point past the last channel
  logic [95:0]  n3InData;
  logic [2:0]   n3InValid, n3InReady;
  logic         n3ForceEn, n3OutValid, n3OutReady;
  logic [1:0]   n3ForceSel, n3OutSel;
  logic [31:0]  n3OutData;

  // Two-channel instance used as a legacy static-select mux
  logic [63:0]  n2InData;
  logic [1:0]   n2InValid, n2InReady;
  logic         n2ForceEn, n2OutValid, n2OutReady;
  logic [0:0]   n2ForceSel, n2OutSel;
  logic [31:0]  n2OutData;

  rr_arb_mux #(.WIDTH(32), .N_IN(4), .ARB_MODE(1)) uRr (
    .clk(clk), .rst_n(rst_n), .in_data(rrInData), .in_valid(rrInValid),
    .in_ready(rrInReady), .force_en(rrForceEn), .force_sel(rrForceSel),
    .out_data(rrOutData), .out_sel(rrOutSel), .out_valid(rrOutValid),
    .out_ready(rrOutReady));

  rr_arb_mux #(.WIDTH(32), .N_IN(4), .ARB_MODE(0)) uFp (
    .clk(clk), .rst_n(rst_n), .in_data(fpInData), .in_valid(fpInValid),
    .in_ready(fpInReady), .force_en(fpForceEn), .force_sel(fpForceSel),
    .out_data(fpOutData), .out_sel(fpOutSel), .out_valid(fpOutValid),
    .out_ready(fpOutReady));

  rr_arb_mux #(.WIDTH(32), .N_IN(3), .ARB_MODE(1)) uN3 (
    .clk(clk), .rst_n(rst_n), .in_data(n3InData), .in_valid(n3InValid),
    .in_ready(n3InReady), .force_en(n3ForceEn), .force_sel(n3ForceSel),
    .out_data(n3OutData), .out_sel(n3OutSel), .out_valid(n3OutValid),
    .out_ready(n3OutReady));

  rr_arb_mux #(.WIDTH(32), .N_IN(2), .ARB_MODE(1)) uN2 (
    .clk(clk), .rst_n(rst_n), .in_data(n2InData), .in_valid(n2InValid),
    .in_ready(n2InReady), .force_en(n2ForceEn), .force_sel(n2ForceSel),
    .out_data(n2OutData), .out_sel(n2OutSel), .out_valid(n2OutValid),
    .out_ready(n2OutReady));

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRr(input string tag, input logic [1:0] expSel,
                         input logic [31:0] expData, input logic expValid);
    checkOutput({tag, "_sel"}, 64'(rrOutSel), 64'(expSel));
    checkOutput({tag, "_data"}, 64'(rrOutData), 64'(expData));
    checkOutput({tag, "_valid"}, 64'(rrOutValid), 64'(expValid));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rrInValid = 4'b1111; rrForceEn = 1'b0; rrForceSel = 2'd0; rrOutReady = 1'b1;
    for (int i = 0; i < 4; i++) rrInData[i*32 +: 32] = 32'h1111_1111 * i;
    fpInData = '0; fpInValid = '0; fpForceEn = 1'b0; fpForceSel = '0; fpOutReady = 1'b1;
    n3InData = '0; n3InValid = '0; n3ForceEn = 1'b0; n3ForceSel = '0; n3OutReady = 1'b1;
    n2InData = '0; n2InValid = '0; n2ForceEn = 1'b0; n2ForceSel = '0; n2OutReady = 1'b1;

    applyStimulus();
    applyStimulus();
    checkRr("reset", 2'd0, 32'h0, 1'b0);
    checkOutput("reset_in_ready", 64'(rrInReady), 64'(4'b0000));

    rst_n = 1'b1;
    #1;
    checkOutput("rr_first_ready", 64'(rrInReady), 64'(4'b0001));

    // Round-robin stream with every channel valid
    applyStimulus(); checkRr("rr0", 2'd0, 32'h0000_0000, 1'b1);
    applyStimulus(); checkRr("rr1", 2'd1, 32'h1111_1111, 1'b1);
    applyStimulus(); checkRr("rr2", 2'd2, 32'h2222_2222, 1'b1);
    applyStimulus(); checkRr("rr3", 2'd3, 32'h3333_3333, 1'b1);
    applyStimulus(); checkRr("rr_wrap", 2'd0, 32'h0000_0000, 1'b1);

    // Backpressure holding a distinctive word
    rrInData[1*32 +: 32] = 32'hAAAA_AAAA;
    applyStimulus(); checkRr("bp_load", 2'd1, 32'hAAAA_AAAA, 1'b1);
    rrOutReady = 1'b0;
    #1;
    checkOutput("bp_ready_low", 64'(rrInReady), 64'(4'b0000));
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      checkRr($sformatf("bp_hold%0d", c), 2'd1, 32'hAAAA_AAAA, 1'b1);
      checkOutput($sformatf("bp_ready%0d", c), 64'(rrInReady), 64'(4'b0000));
    end
    rrOutReady = 1'b1;
    #1;
    checkOutput("bp_resume_ready", 64'(rrInReady), 64'(4'b0100));
    applyStimulus(); checkRr("bp_resume", 2'd2, 32'h2222_2222, 1'b1);

    // Force channel 2; pointer must stay at 3
    rrForceEn = 1'b1; rrForceSel = 2'd2;
    #1;
    checkOutput("force_ready", 64'(rrInReady), 64'(4'b0100));
    applyStimulus(); checkRr("force_a", 2'd2, 32'h2222_2222, 1'b1);
    applyStimulus(); checkRr("force_b", 2'd2, 32'h2222_2222, 1'b1);
    rrForceEn = 1'b0;
    #1;
    checkOutput("force_ptr_held", 64'(rrInReady), 64'(4'b1000));
    applyStimulus(); checkRr("force_after", 2'd3, 32'h3333_3333, 1'b1);

    // Asynchronous reset mid-cycle while holding a word
    #2;
    rst_n = 1'b0;
    #1;
    checkRr("async_reset", 2'd0, 32'h0, 1'b0);
    checkOutput("async_reset_ready", 64'(rrInReady), 64'(4'b0000));
    rrInData[0 +: 32] = 32'h5A5A_5A5A;
    applyStimulus();
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_ready", 64'(rrInReady), 64'(4'b0001));
    applyStimulus(); checkRr("post_reset_ch0", 2'd0, 32'h5A5A_5A5A, 1'b1);
    rrInValid = 4'b0000;
    applyStimulus(); checkOutput("rr_idle_valid", 64'(rrOutValid), 64'(1'b0));

    // Fixed priority: channel 1 always beats channel 3
    for (int i = 0; i < 4; i++) fpInData[i*32 +: 32] = 32'hF0F0_0000 + i;
    fpInValid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1;
      checkOutput($sformatf("fp_ready%0d", c), 64'(fpInReady), 64'(4'b0010));
      applyStimulus();
      checkOutput($sformatf("fp_sel%0d", c), 64'(fpOutSel), 64'(2'd1));
      checkOutput($sformatf("fp_data%0d", c), 64'(fpOutData), 64'(32'hF0F0_0001));
    end

    // Forced index beyond the last channel empties the eligible set
    for (int i = 0; i < 3; i++) n3InData[i*32 +: 32] = 32'hC0DE_0000 + i;
    n3InValid = 3'b111; n3ForceEn = 1'b1; n3ForceSel = 2'd1;
    applyStimulus();
    checkOutput("n3_force_sel", 64'(n3OutSel), 64'(2'd1));
    checkOutput("n3_force_data", 64'(n3OutData), 64'(32'hC0DE_0001));
    checkOutput("n3_force_valid", 64'(n3OutValid), 64'(1'b1));
    n3ForceSel = 2'd3;
    #1;
    checkOutput("n3_oor_ready", 64'(n3InReady), 64'(3'b000));
    applyStimulus();
    checkOutput("n3_oor_valid", 64'(n3OutValid), 64'(1'b0));
    checkOutput("n3_oor_data_hold", 64'(n3OutData), 64'(32'hC0DE_0001));
    checkOutput("n3_oor_sel_hold", 64'(n3OutSel), 64'(2'd1));

    // Legacy 2:1 static select
    n2InData = {32'hFFFF_FFFF, 32'h0000_0000};
    n2InValid = 2'b11; n2ForceEn = 1'b1; n2ForceSel = 1'b0;
    applyStimulus();
    checkOutput("legacy_sel0", 64'(n2OutData), 64'(32'h0000_0000));
    checkOutput("legacy_sel0_valid", 64'(n2OutValid), 64'(1'b1));
    n2ForceSel = 1'b1;
    applyStimulus();
    checkOutput("legacy_sel1", 64'(n2OutData), 64'(32'hFFFF_FFFF));
    checkOutput("legacy_sel1_idx", 64'(n2OutSel), 64'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
